lfsr_num_bank: RTL and testbench

//  Parametrised multi-channel pseudo-random number source for the user-area wrapper. It drives pad and LA output fields.
//  NUM_CH independent Galois LFSRs, each exposing a NUM_W-bit number. Adds a programmable step prescaler,
//  a free-run / step-on-request mode with a 4-phase handshake, runtime per-channel seed load, and an output lock.

---
 rtl/lfsr_num_pkg.sv | 33 +++
 rtl/lfsr_galois_cell.sv | 35 +++
 rtl/lfsr_num_bank.sv | 124 ++++++++++++
 tb/tb_lfsr_num_bank.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_num_pkg.sv
// Shared types and constants for the LFSR number bank.
// Mode and step-FSM encodings plus the per-channel reset seed.
package lfsr_num_pkg;

  typedef enum logic {
    MODE_FREE = 1'b0,
    MODE_STEP = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STEP,
    ST_ACK
  } step_st_e;

  localparam logic [15:0] DEF_POLY = 16'hB400;
  localparam logic [15:0] DEF_SEED = 16'hACE1;
  localparam logic [15:0] CH_SALT  = 16'h1111;

  // Salted per-channel seed; a zero result would lock up, so fall back.
  function automatic logic [31:0] reset_seed(
    input logic [31:0] seed,
    input int unsigned ch,
    input int unsigned w
  );
    logic [31:0] mask;
    logic [31:0] r;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    r    = (seed ^ (ch * {16'd0, CH_SALT})) & mask;
    return (r == '0) ? (seed & mask) : r;
  endfunction

endpackage

// File: rtl/lfsr_galois_cell.sv
// One Galois LFSR channel: advance, seed load, zero-seed substitution.
// A load wins over an advance in the same cycle.
module lfsr_galois_cell
  import lfsr_num_pkg::*;
#(
  parameter int              W    = 16,
  parameter logic [W-1:0]    POLY = W'(DEF_POLY),
  parameter logic [W-1:0]    SEED = W'(DEF_SEED),
  parameter logic [W-1:0]    RST  = W'(DEF_SEED)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         adv,
  input  logic         ld,
  input  logic [W-1:0] ld_dat,
  output logic [W-1:0] state,
  output logic [W-1:0] nxt
);

  always_comb begin
    nxt = state;
    if (ld)
      nxt = (ld_dat == '0) ? SEED : ld_dat;
    else if (adv)
      nxt = (state >> 1) ^ (state[0] ? POLY : '0);
  end

  always_ff @(posedge clock) begin
    if (reset)
      state <= RST;
    else
      state <= nxt;
  end

endmodule

// File: rtl/lfsr_num_bank.sv
// Multi-channel LFSR number source with prescaler and step handshake.
// Define LFSR_PERIOD_CNT_EN to add the step_cnt_o advance counter.
module lfsr_num_bank
  import lfsr_num_pkg::*;
#(
  parameter int                NUM_CH = 4,
  parameter int                NUM_W  = 7,
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] POLY   = LFSR_W'(DEF_POLY),
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEF_SEED),
  parameter int                DIV_W  = 8,
  localparam int               CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    mode_i,
  input  logic [DIV_W-1:0]        div_i,
  input  logic                    lock_i,
  input  logic                    step_req_i,
  output logic                    step_ack_o,
  input  logic                    seed_vld_i,
  output logic                    seed_rdy_o,
  input  logic [CH_W-1:0]         seed_ch_i,
  input  logic [LFSR_W-1:0]       seed_dat_i,
  output logic [NUM_CH*NUM_W-1:0] num_o,
  output logic                    num_vld_o
`ifdef LFSR_PERIOD_CNT_EN
  ,
  output logic [LFSR_W-1:0]       step_cnt_o
`endif
);

  step_st_e                     st;
  logic [DIV_W-1:0]             div_cnt;
  logic                         free_run;
  logic                         free_adv;
  logic                         adv;
  logic                         ld_ok;
  logic [NUM_CH*NUM_W-1:0]      num_nxt;
  logic [NUM_CH*NUM_W-1:0]      num_rst;
  logic [NUM_CH-1:0][LFSR_W-1:0] state;
  logic [NUM_CH-1:0][LFSR_W-1:0] nxt;

  // Mode is only consulted in IDLE, so a mid-handshake change waits.
  assign free_run   = (st == ST_IDLE) && (mode_e'(mode_i) == MODE_FREE);
  assign free_adv   = free_run && (div_cnt == div_i);
  assign adv        = free_adv || (st == ST_STEP);
  assign seed_rdy_o = (st != ST_STEP);
  assign ld_ok      = seed_vld_i && seed_rdy_o;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [LFSR_W-1:0] RS =
      LFSR_W'(reset_seed(32'(SEED), c, LFSR_W));

    lfsr_galois_cell #(
      .W   (LFSR_W),
      .POLY(POLY),
      .SEED(SEED),
      .RST (RS)
    ) u_cell (
      .clock (clock),
      .reset (reset),
      .adv   (adv),
      .ld    (ld_ok && (32'(seed_ch_i) == c)),
      .ld_dat(seed_dat_i),
      .state (state[c]),
      .nxt   (nxt[c])
    );

    assign num_nxt[c*NUM_W +: NUM_W] = nxt[c][NUM_W-1:0];
    assign num_rst[c*NUM_W +: NUM_W] = RS[NUM_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st         <= ST_IDLE;
      div_cnt    <= '0;
      step_ack_o <= 1'b0;
      num_vld_o  <= 1'b0;
      num_o      <= num_rst;
    end else begin
      num_vld_o <= adv && !lock_i;
      if (adv && !lock_i)
        num_o <= num_nxt;

      if (free_run)
        div_cnt <= free_adv ? '0 : div_cnt + 1'b1;
      else
        div_cnt <= '0;

      unique case (st)
        ST_IDLE: begin
          if (mode_e'(mode_i) == MODE_STEP && step_req_i)
            st <= ST_STEP;
        end
        ST_STEP: begin
          st         <= ST_ACK;
          step_ack_o <= 1'b1;
        end
        ST_ACK: begin
          if (!step_req_i) begin
            st         <= ST_IDLE;
            step_ack_o <= 1'b0;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

`ifdef LFSR_PERIOD_CNT_EN
  logic [LFSR_W-1:0] step_cnt_q;

  always_ff @(posedge clock) begin
    if (reset)
      step_cnt_q <= '0;
    else if (adv)
      step_cnt_q <= step_cnt_q + 1'b1;
  end

  assign step_cnt_o = step_cnt_q;
`endif

endmodule

// File: tb/tb_lfsr_num_bank.sv
// Randomised self-checking bench for lfsr_num_bank.
// A second 5-channel instance exercises out-of-range seed channels.
module tb_lfsr_num_bank;

  localparam int          NCH  = 4;
  localparam int          NW   = 7;
  localparam logic [15:0] POLY = 16'hB400;
  localparam logic [15:0] SEED = 16'hACE1;

  logic              clk = 1'b0;
  logic              reset;
  logic              mode;
  logic [7:0]        div;
  logic              lock;
  logic              step_req;
  logic              step_ack;
  logic              seed_vld;
  logic              seed_rdy;
  logic [1:0]        seed_ch;
  logic [15:0]       seed_dat;
  logic [NCH*NW-1:0] num;
  logic              num_vld;

  logic              seed_vld5;
  logic [2:0]        seed_ch5;
  logic              ack5;
  logic              rdy5;
  logic [5*NW-1:0]   num5;
  logic              vld5;

`ifdef LFSR_PERIOD_CNT_EN
  logic [15:0]       step_cnt;
  logic [15:0]       step_cnt5;
`endif

  always #5 clk = ~clk;

  lfsr_num_bank u_dut (
    .clock     (clk),
    .reset     (reset),
    .mode_i    (mode),
    .div_i     (div),
    .lock_i    (lock),
    .step_req_i(step_req),
    .step_ack_o(step_ack),
    .seed_vld_i(seed_vld),
    .seed_rdy_o(seed_rdy),
    .seed_ch_i (seed_ch),
    .seed_dat_i(seed_dat),
    .num_o     (num),
    .num_vld_o (num_vld)
`ifdef LFSR_PERIOD_CNT_EN
    ,
    .step_cnt_o(step_cnt)
`endif
  );

  lfsr_num_bank #(.NUM_CH(5)) u_dut5 (
    .clock     (clk),
    .reset     (reset),
    .mode_i    (mode),
    .div_i     (div),
    .lock_i    (lock),
    .step_req_i(step_req),
    .step_ack_o(ack5),
    .seed_vld_i(seed_vld5),
    .seed_rdy_o(rdy5),
    .seed_ch_i (seed_ch5),
    .seed_dat_i(seed_dat),
    .num_o     (num5),
    .num_vld_o (vld5)
`ifdef LFSR_PERIOD_CNT_EN
    ,
    .step_cnt_o(step_cnt5)
`endif
  );

  int          vectors = 0;
  int          errors  = 0;
  logic [15:0] ms [NCH];
  logic [7:0]  mcnt;
  logic [NCH*NW-1:0] exp_num;
  int unsigned adv_total;

  function automatic logic [15:0] stepf(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? POLY : 16'h0000);
  endfunction

  function automatic logic [15:0] rseed(input int c);
    logic [15:0] r;
    r = SEED ^ 16'(c * 16'h1111);
    return (r == 16'h0) ? SEED : r;
  endfunction

  function automatic logic [NCH*NW-1:0] pack_num();
    logic [NCH*NW-1:0] p;
    for (int c = 0; c < NCH; c++)
      p[c*NW +: NW] = ms[c][NW-1:0];
    return p;
  endfunction

  task automatic reset_dut();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < NCH; c++)
      ms[c] = rseed(c);
    mcnt      = 8'd0;
    exp_num   = pack_num();
    adv_total = 0;
  endtask

  // One clock with the FSM idle and no request; the model predicts it.
  task automatic tick();
    logic        a;
    logic        ev;
    logic [15:0] nx [NCH];
    a = (mode == 1'b0) && (mcnt == div);
    if (mode == 1'b0)
      mcnt = a ? 8'd0 : mcnt + 8'd1;
    else
      mcnt = 8'd0;
    for (int c = 0; c < NCH; c++)
      nx[c] = a ? stepf(ms[c]) : ms[c];
    if (seed_vld)
      nx[seed_ch] = (seed_dat == 16'h0) ? SEED : seed_dat;
    for (int c = 0; c < NCH; c++)
      ms[c] = nx[c];
    if (a && !lock)
      exp_num = pack_num();
    if (a)
      adv_total++;
    ev = a && !lock;
    @(posedge clk);
    #1;
    seed_vld = 1'b0;
    vectors++;
    if (num !== exp_num) begin
      errors++;
      $display("FAIL tick_num: got %h exp %h", num, exp_num);
    end
    vectors++;
    if (num_vld !== ev) begin
      errors++;
      $display("FAIL tick_vld: got %b exp %b", num_vld, ev);
    end
`ifdef LFSR_PERIOD_CNT_EN
    vectors++;
    if (step_cnt !== 16'(adv_total)) begin
      errors++;
      $display("FAIL tick_cnt: got %h exp %h", step_cnt, 16'(adv_total));
    end
`endif
  endtask

  // One 4-phase step; expects mode=1 and the FSM idle on entry.
  task automatic do_step(input int hold);
    step_req = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (seed_rdy !== 1'b0 || step_ack !== 1'b0 || num_vld !== 1'b0) begin
      errors++;
      $display("FAIL step_enter: rdy %b ack %b vld %b exp 0 0 0",
               seed_rdy, step_ack, num_vld);
    end
    for (int c = 0; c < NCH; c++)
      ms[c] = stepf(ms[c]);
    if (!lock)
      exp_num = pack_num();
    adv_total++;
    @(posedge clk);
    #1;
    vectors++;
    if (num !== exp_num || num_vld !== !lock) begin
      errors++;
      $display("FAIL step_adv: num %h vld %b exp %h %b",
               num, num_vld, exp_num, !lock);
    end
    vectors++;
    if (step_ack !== 1'b1 || seed_rdy !== 1'b1) begin
      errors++;
      $display("FAIL step_ack: ack %b rdy %b exp 1 1", step_ack, seed_rdy);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (step_ack !== 1'b1 || num_vld !== 1'b0 || num !== exp_num) begin
        errors++;
        $display("FAIL step_hold: ack %b vld %b num %h exp 1 0 %h",
                 step_ack, num_vld, num, exp_num);
      end
    end
    step_req = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (step_ack !== 1'b0 || num !== exp_num) begin
      errors++;
      $display("FAIL step_release: ack %b num %h exp 0 %h",
               step_ack, num, exp_num);
    end
  endtask

  task automatic test_reset();
    logic [NCH*NW-1:0] rv;
    rv = {7'h52, 7'h43, 7'h70, 7'h61};
    mode = 1'b0;
    div  = 8'd0;
    lock = 1'b0;
    reset_dut();
    vectors++;
    if (num !== rv) begin
      errors++;
      $display("FAIL reset_num: got %h exp %h", num, rv);
    end
    vectors++;
    if (num_vld !== 1'b0 || seed_rdy !== 1'b1 || step_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: vld %b rdy %b ack %b exp 0 1 0",
               num_vld, seed_rdy, step_ack);
    end
  endtask

  task automatic test_first_advance();
    tick();
    vectors++;
    if (num[NW-1:0] !== 7'h70) begin
      errors++;
      $display("FAIL first_adv: got %h exp 70", num[NW-1:0]);
    end
  endtask

  task automatic test_div3();
    int pulses = 0;
    div = 8'd3;
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      tick();
      if (num_vld === 1'b1)
        pulses++;
    end
    vectors++;
    if (pulses != 4) begin
      errors++;
      $display("FAIL div3_pulses: got %0d exp 4", pulses);
    end
  endtask

  task automatic test_lock();
    div = 8'd0;
    reset_dut();
    repeat (2) tick();
    lock = 1'b1;
    repeat (10) tick();
    lock = 1'b0;
    tick();
  endtask

  task automatic test_step();
    mode = 1'b1;
    tick();
    do_step(1);
    do_step(20);
    mode = 1'b0;
  endtask

  task automatic test_reset_in_ack();
    mode     = 1'b1;
    step_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (step_ack !== 1'b1) begin
      errors++;
      $display("FAIL ack_before_reset: got %b exp 1", step_ack);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    step_req = 1'b0;
    mode     = 1'b0;
    reset_dut();
    vectors++;
    if (step_ack !== 1'b0 || seed_rdy !== 1'b1 || num !== exp_num) begin
      errors++;
      $display("FAIL reset_in_ack: ack %b rdy %b num %h exp 0 1 %h",
               step_ack, seed_rdy, num, exp_num);
    end
    mode = 1'b1;
    tick();
    do_step(2);
    mode = 1'b0;
  endtask

  task automatic test_seed();
    mode = 1'b1;
    reset_dut();
    seed_vld = 1'b1;
    seed_ch  = 2'd2;
    seed_dat = 16'h0000;
    tick();
    do_step(0);
    vectors++;
    if (num[2*NW +: NW] !== 7'h70) begin
      errors++;
      $display("FAIL seed_zero: got %h exp 70", num[2*NW +: NW]);
    end
    mode = 1'b0;
    div  = 8'd0;
    tick();
    seed_vld = 1'b1;
    seed_ch  = 2'd1;
    seed_dat = 16'h0001;
    tick();
    vectors++;
    if (num[NW +: NW] !== 7'h01) begin
      errors++;
      $display("FAIL seed_with_adv: got %h exp 01", num[NW +: NW]);
    end
  endtask

  task automatic test_seed_oob();
    logic [5*NW-1:0] e5;
    mode = 1'b1;
    reset_dut();
    tick();
    seed_vld5 = 1'b1;
    seed_ch5  = 3'd5;
    seed_dat  = 16'h1234;
    tick();
    seed_vld5 = 1'b1;
    seed_ch5  = 3'd7;
    seed_dat  = 16'h0F0F;
    tick();
    seed_vld5 = 1'b0;
    do_step(0);
    for (int c = 0; c < 5; c++)
      e5[c*NW +: NW] = stepf(rseed(c)) & 16'h007F;
    vectors++;
    if (num5 !== e5) begin
      errors++;
      $display("FAIL seed_oob: got %h exp %h", num5, e5);
    end
    mode = 1'b0;
  endtask

  task automatic test_random();
    mode = 1'b0;
    div  = 8'd0;
    reset_dut();
    for (int i = 0; i < 300; i++) begin
      if (i % 25 == 0)
        div = 8'($urandom_range(0, 4));
      lock     = ($urandom_range(0, 3) == 0);
      seed_vld = ($urandom_range(0, 4) == 0);
      seed_ch  = 2'($urandom_range(0, 3));
      seed_dat = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      tick();
    end
    lock = 1'b0;
  endtask

`ifdef LFSR_PERIOD_CNT_EN
  task automatic test_cnt();
    mode = 1'b0;
    div  = 8'd0;
    lock = 1'b0;
    reset_dut();
    repeat (100) tick();
    vectors++;
    if (step_cnt !== 16'd100) begin
      errors++;
      $display("FAIL cnt_100: got %0d exp 100", step_cnt);
    end
    reset_dut();
    repeat (65535) @(posedge clk);
    #1;
    vectors++;
    if (step_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL cnt_max: got %h exp ffff", step_cnt);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (step_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL cnt_wrap: got %h exp 0000", step_cnt);
    end
    reset_dut();
  endtask
`endif

  initial begin
    reset     = 1'b1;
    mode      = 1'b0;
    div       = 8'd0;
    lock      = 1'b0;
    step_req  = 1'b0;
    seed_vld  = 1'b0;
    seed_ch   = 2'd0;
    seed_dat  = 16'h0;
    seed_vld5 = 1'b0;
    seed_ch5  = 3'd0;
    test_reset();
    test_first_advance();
    test_div3();
    test_lock();
    test_step();
    test_reset_in_ack();
    test_seed();
    test_seed_oob();
    test_random();
`ifdef LFSR_PERIOD_CNT_EN
    test_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
